sound_gen_multi: RTL and testbench



---
 rtl/sound_gen_multi_if.sv | 26 ++
 rtl/sound_gen_multi.sv | 156 +++++++++++++++
 tb/tb_sound_gen_multi.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sound_gen_multi_if.sv
// Strobe, configuration and stereo sample bundle between a controller and sound_gen_multi.
interface sound_gen_multi_if #(
    parameter int VOICES   = 4,
    parameter int SAMPLE_W = 16
);
    localparam int AW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic                       sample_strobe;
    logic                       cfg_we;
    logic [AW-1:0]              cfg_addr;
    logic [15:0]                cfg_data;
    logic signed [SAMPLE_W-1:0] left_sample;
    logic signed [SAMPLE_W-1:0] right_sample;
    logic                       sample_valid;
    logic                       busy;

    modport master (
        output sample_strobe, cfg_we, cfg_addr, cfg_data,
        input  left_sample, right_sample, sample_valid, busy
    );

    modport slave (
        input  sample_strobe, cfg_we, cfg_addr, cfg_data,
        output left_sample, right_sample, sample_valid, busy
    );
endinterface

// File: rtl/sound_gen_multi.sv
// Multi-voice tone generator: one voice per clock over a shared datapath,
// summed into saturated stereo samples on each sample strobe.
//   state | meaning
//   IDLE  | waiting for sample_strobe
//   RUN   | evaluating voice v_q, one per cycle
//   DONE  | saturating accumulators into the output registers
module sound_gen_multi #(
    parameter int VOICES   = 4,
    parameter int SAMPLE_W = 16,
    parameter int LFSR_W   = 21
) (
    input logic              clk,
    input logic              rst_n,
    sound_gen_multi_if.slave bus
);
    localparam int AW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + $clog2(VOICES) + 1;

    localparam logic signed [SAMPLE_W-1:0] POS_M   = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] NEG_M   = -POS_M;
    localparam logic signed [ACC_W-1:0]    ACC_MAX = {{(ACC_W-SAMPLE_W){1'b0}}, POS_M};
    localparam logic signed [ACC_W-1:0]    ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [LFSR_W-1:0] ctrl_seed();
        logic [LFSR_W-1:0] s;
        for (int i = 0; i < LFSR_W; i++) s[i] = (((LFSR_W - 1 - i) % 2) == 0);
        return s;
    endfunction

    localparam logic [LFSR_W-1:0] CTRL_SEED  = ctrl_seed();
    localparam logic [LFSR_W-1:0] NOISE_SEED = LFSR_W'(8'h55);

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
        return {x[LFSR_W-2:0], x[LFSR_W-1] ^ x[LFSR_W-2]};
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > ACC_MAX) return POS_M;
        if (a < ACC_MIN) return ~POS_M;
        return a[SAMPLE_W-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic [31:0]                mc_q, mc_d;
    logic [LFSR_W-1:0]          noise_q, noise_d;
    logic [LFSR_W-1:0]          ctrl_q, ctrl_d;
    logic [AW-1:0]              v_q, v_d;
    logic signed [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
    logic                       valid_q, valid_d;
    logic [13:0]                cfg_q [VOICES];

    logic [13:0]                cfg_v;
    logic signed [31:0]         phase;
    logic [SAMPLE_W-1:0]        p, bb;
    logic signed [SAMPLE_W-1:0] raw, shaped;
    logic signed [ACC_W-1:0]    contrib;
    logic                       voice_on;
    logic                       unused_bits;

    assign cfg_v = cfg_q[v_q];
    // mc is read as signed so large rates sign-extend the phase
    assign phase    = $signed(mc_q) >>> cfg_v[12:8];
    assign p        = phase[SAMPLE_W-1:0];
    assign bb       = p & (p >> 8);
    assign shaped   = raw >>> cfg_v[7:5];
    assign contrib  = {{(ACC_W-SAMPLE_W){shaped[SAMPLE_W-1]}}, shaped};
    assign voice_on = cfg_v[2] && (!cfg_v[13] || ctrl_q[LFSR_W - 1 - 32'(v_q)]);

    assign unused_bits = ^{bus.cfg_data[15:14], phase[31:SAMPLE_W]};

    always_comb begin
        raw = NEG_M;
        unique case (cfg_v[1:0])
            2'd0: raw = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
            2'd1: raw = p[SAMPLE_W-1] ? POS_M : NEG_M;
            2'd2: raw = noise_q[LFSR_W-1] ? POS_M : NEG_M;
            default: raw = {~bb[SAMPLE_W-1], bb[SAMPLE_W-2:0]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        noise_d = noise_q;
        ctrl_d  = ctrl_q;
        v_d     = v_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        left_d  = left_q;
        right_d = right_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.sample_strobe) begin
                    mc_d    = mc_q - 32'd1;
                    noise_d = lfsr_step(noise_q);
                    ctrl_d  = lfsr_step(ctrl_q);
                    acc_l_d = '0;
                    acc_r_d = '0;
                    v_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (voice_on && cfg_v[3]) acc_l_d = acc_l_q + contrib;
                if (voice_on && cfg_v[4]) acc_r_d = acc_r_q + contrib;
                v_d = v_q + 1'b1;
                if (v_q == AW'(VOICES - 1)) state_d = DONE;
            end
            DONE: begin
                left_d  = saturate(acc_l_q);
                right_d = saturate(acc_r_q);
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mc_q    <= 32'hFFFE_53FF;
            noise_q <= NOISE_SEED;
            ctrl_q  <= CTRL_SEED;
            v_q     <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < VOICES; i++) cfg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            noise_q <= noise_d;
            ctrl_q  <= ctrl_d;
            v_q     <= v_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            if (bus.cfg_we && (32'(bus.cfg_addr) < 32'(VOICES)))
                cfg_q[bus.cfg_addr] <= bus.cfg_data[13:0];
        end
    end

    assign bus.left_sample  = left_q;
    assign bus.right_sample = right_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_sound_gen_multi.sv
// Directed bench for sound_gen_multi with VOICES=4, SAMPLE_W=16, LFSR_W=21.
module tb_sound_gen_multi;
    localparam int VOICES   = 4;
    localparam int SAMPLE_W = 16;
    localparam int LFSR_W   = 21;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sound_gen_multi_if #(.VOICES(VOICES), .SAMPLE_W(SAMPLE_W)) bus();

    sound_gen_multi #(.VOICES(VOICES), .SAMPLE_W(SAMPLE_W), .LFSR_W(LFSR_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0]       mc_m;
    logic [LFSR_W-1:0] noise_m, ctrl_m;

    function automatic logic [LFSR_W-1:0] lfsr(input logic [LFSR_W-1:0] x);
        return {x[LFSR_W-2:0], x[LFSR_W-1] ^ x[LFSR_W-2]};
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.sample_strobe = 1'b0;
        bus.cfg_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.sample_valid, 0);
        chk("rst_left", bus.left_sample, 0);
        chk("rst_right", bus.right_sample, 0);
        rst_n = 1'b1;
        mc_m    = 32'hFFFE_53FF;
        noise_m = 21'h55;
        ctrl_m  = 21'h15_5555;   // 1010... with the msb set
    endtask

    task automatic cfg_write(input int a, input logic [15:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'(a);
        bus.cfg_data = d;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic run_sample(output logic signed [SAMPLE_W-1:0] l, output logic signed [SAMPLE_W-1:0] r);
        int bc;
        bc = 0;
        bus.sample_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_strobe = 1'b0;
        mc_m    = mc_m - 32'd1;
        noise_m = lfsr(noise_m);
        ctrl_m  = lfsr(ctrl_m);
        for (int k = 0; k < VOICES + 1; k++) begin
            if (bus.busy === 1'b1 && bus.sample_valid === 1'b0) bc++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles", bc, VOICES + 1);
        chk("valid_pulse", bus.sample_valid, 1);
        chk("busy_clear", bus.busy, 0);
        l = bus.left_sample;
        r = bus.right_sample;
        @(posedge clk);
        #1;
        chk("valid_one_cycle", bus.sample_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [SAMPLE_W-1:0] l, r;
        logic [15:0] saw_e;
        int nv;

        bus.sample_strobe = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;

        // silent sample after reset
        do_reset();
        run_sample(l, r);
        chk("silent_L", l, 0);
        chk("silent_R", r, 0);

        // square, rate 31, pan left, shift 1
        do_reset();
        cfg_write(0, 16'h1F2D);
        run_sample(l, r);
        chk("square_L", l, 16383);
        chk("square_R", r, 0);

        // saw on voice1, rate 0, pan right
        do_reset();
        cfg_write(1, 16'h0014);
        run_sample(l, r);
        chk("saw1_R", r, -11266);
        chk("saw1_L", l, 0);
        run_sample(l, r);
        chk("saw2_R", r, -11267);

        // positive saturation: four full-scale squares on both sides
        for (int v = 0; v < VOICES; v++) cfg_write(v, 16'h1F1D);
        run_sample(l, r);
        chk("satpos_L", l, 32767);
        chk("satpos_R", r, 32767);

        // negative saturation via bytebeat at rate 31 (-32513 per voice)
        for (int v = 0; v < VOICES; v++) cfg_write(v, 16'h1F1F);
        run_sample(l, r);
        chk("satneg_L", l, -32768);
        chk("satneg_R", r, -32768);

        // single bytebeat voice, no saturation
        for (int v = 0; v < VOICES; v++) cfg_write(v, (v == 2) ? 16'h1F0F : 16'h0000);
        run_sample(l, r);
        chk("byte_L", l, -32513);
        chk("byte_R", r, 0);

        // noise voice, full scale then shifted by 7
        cfg_write(2, 16'h0000);
        cfg_write(0, 16'h000E);
        run_sample(l, r);
        chk("noise_L", l, noise_m[LFSR_W-1] ? 32767 : -32767);
        cfg_write(0, 16'h00EE);
        run_sample(l, r);
        chk("noise_shift_L", l, noise_m[LFSR_W-1] ? 255 : -256);

        // strobe while busy is dropped
        cfg_write(0, 16'h0000);
        cfg_write(1, 16'h0014);
        nv = 0;
        bus.sample_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_strobe = 1'b0;
        mc_m    = mc_m - 32'd1;
        noise_m = lfsr(noise_m);
        ctrl_m  = lfsr(ctrl_m);
        @(posedge clk);
        #1;
        if (bus.sample_valid === 1'b1) nv++;
        bus.sample_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_strobe = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.sample_valid === 1'b1) nv++;
            @(posedge clk);
            #1;
        end
        chk("drop_valid_count", nv, 1);
        saw_e = mc_m[15:0];
        saw_e[15] = ~saw_e[15];
        chk("drop_saw_R", bus.right_sample, $signed(saw_e));
        run_sample(l, r);
        saw_e = mc_m[15:0];
        saw_e[15] = ~saw_e[15];
        chk("after_drop_saw_R", r, $signed(saw_e));

        // gated square follows the control LFSR msb
        cfg_write(1, 16'h0000);
        cfg_write(0, 16'h3F0D);
        for (int s = 0; s < 8; s++) begin
            run_sample(l, r);
            chk("gate_L", l, ctrl_m[LFSR_W-1] ? 32767 : 0);
        end

        // reset in the middle of RUN
        cfg_write(0, 16'h1F1D);
        nv = 0;
        bus.sample_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_strobe = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.sample_valid === 1'b1) nv++;
        end
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_L", bus.left_sample, 0);
        chk("midrst_R", bus.right_sample, 0);
        rst_n = 1'b1;
        mc_m    = 32'hFFFE_53FF;
        noise_m = 21'h55;
        ctrl_m  = 21'h15_5555;
        for (int k = 0; k < 8; k++) begin
            if (bus.sample_valid === 1'b1) nv++;
            @(posedge clk);
            #1;
        end
        chk("midrst_no_valid", nv, 0);
        cfg_write(1, 16'h0014);
        run_sample(l, r);
        chk("midrst_cfg_cleared_L", l, 0);
        chk("midrst_first_R", r, -11266);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
